// File: rtl/pc_fetch_unit.sv
// PC register and instruction-fetch front end: issues imem requests, buffers up
// to two {pc, instr} pairs for decode and applies taken-branch redirects.
module pc_fetch_unit #(
  parameter int                    RV_BIT_NUM = 32,
  parameter logic [RV_BIT_NUM-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  redirect_valid,
  input  logic [RV_BIT_NUM-1:0] redirect_pc,
  output logic [RV_BIT_NUM-1:0] pc_seq,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [RV_BIT_NUM-1:0] imem_req_addr,
  input  logic                  imem_rsp_valid,
  input  logic [31:0]           imem_rsp_data,
  output logic                  if_valid,
  input  logic                  if_ready,
  output logic [RV_BIT_NUM-1:0] if_pc,
  output logic [31:0]           if_instr
);

  typedef enum logic {
    ST_HOLD = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic [RV_BIT_NUM-1:0] pc_q, pc_d;
  logic [RV_BIT_NUM-1:0] req_pc_q, req_pc_d;
  logic                  inflight_q, inflight_d;
  logic                  kill_q, kill_d;
  logic [RV_BIT_NUM-1:0] fifo_pc_q    [2];
  logic [RV_BIT_NUM-1:0] fifo_pc_d    [2];
  logic [31:0]           fifo_instr_q [2];
  logic [31:0]           fifo_instr_d [2];
  logic                  wr_ptr_q, wr_ptr_d;
  logic                  rd_ptr_q, rd_ptr_d;
  logic [1:0]            count_q, count_d;

  logic                  run;
  logic                  redirect;
  logic [2:0]            occupancy;
  logic                  req_valid;
  logic                  accept;
  logic                  rsp_take;
  logic                  push;
  logic                  pop;
  logic                  unused_redirect_lsbs;

  // Target addresses are word aligned; the low two bits of the mux output are dropped.
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_HOLD;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_HOLD: state_d = ST_RUN;
      ST_RUN:  state_d = ST_RUN;
    endcase
  end

  // Issue gating counts the inflight response so it always has a free slot.
  always_comb begin
    run       = (state_q == ST_RUN);
    redirect  = run && redirect_valid;
    occupancy = {1'b0, count_q} + {2'b00, inflight_q};
    req_valid = run && !redirect_valid && (occupancy < 3'd2);
    accept    = req_valid && imem_req_ready;
    rsp_take  = imem_rsp_valid && inflight_q;
    push      = rsp_take && !kill_q && !redirect;
    pop       = (count_q != 2'd0) && if_ready;
  end

  always_comb begin
    pc_d       = pc_q;
    req_pc_d   = req_pc_q;
    inflight_d = inflight_q;
    kill_d     = kill_q;
    if (redirect) begin
      pc_d = {redirect_pc[RV_BIT_NUM-1:2], 2'b00};
    end else if (accept) begin
      pc_d     = pc_q + RV_BIT_NUM'(4);
      req_pc_d = pc_q;
    end
    if (accept) begin
      inflight_d = 1'b1;
    end else if (rsp_take) begin
      inflight_d = 1'b0;
    end
    if (rsp_take) begin
      kill_d = 1'b0;
    end
    // A redirect whose response has not shown up yet must drop it on arrival.
    if (redirect && inflight_q && !imem_rsp_valid) begin
      kill_d = 1'b1;
    end
  end

  always_comb begin
    fifo_pc_d    = fifo_pc_q;
    fifo_instr_d = fifo_instr_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    if (redirect) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (push) begin
        fifo_pc_d[wr_ptr_q]    = req_pc_q;
        fifo_instr_d[wr_ptr_q] = imem_rsp_data;
        wr_ptr_d               = ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      count_d = count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      req_pc_q   <= '0;
      inflight_q <= 1'b0;
      kill_q     <= 1'b0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        fifo_pc_q[i]    <= '0;
        fifo_instr_q[i] <= '0;
      end
    end else begin
      pc_q         <= pc_d;
      req_pc_q     <= req_pc_d;
      inflight_q   <= inflight_d;
      kill_q       <= kill_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      fifo_pc_q    <= fifo_pc_d;
      fifo_instr_q <= fifo_instr_d;
    end
  end

  assign pc_seq         = pc_q + RV_BIT_NUM'(4);
  assign imem_req_valid = req_valid;
  assign imem_req_addr  = pc_q;
  assign if_valid       = (count_q != 2'd0);
  assign if_pc          = if_valid ? fifo_pc_q[rd_ptr_q] : '0;
  assign if_instr       = if_valid ? fifo_instr_q[rd_ptr_q] : '0;

endmodule
